// File: rtl/pow5_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : pow5_sum_accum
// Brief    : Sums ACC_LEN consecutive valid pow5 results into one frame sum.
//            Each sum is offered on a valid/ready port. The upstream stage
//            cannot be stalled, so a frame that completes while the output
//            still holds an unconsumed sum is discarded and flagged on drop_o.
// Options  : POW5_SUM_ACCUM_DROP_CNT_EN adds drop_cnt_o, a saturating 8-bit
//            count of discarded frames.
// Revision : 1.0 - initial release
// ============================================================================
module pow5_sum_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_WIDTH   = 5 * DATA_WIDTH,
    parameter int ACC_LEN    = 4,
    parameter int SUM_WIDTH  = IN_WIDTH + $clog2(ACC_LEN)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [IN_WIDTH-1:0]        pow_data_i,
    input  logic                       data_valid_i,
    output logic [SUM_WIDTH-1:0]       sum_o,
    output logic                       sum_valid_o,
    input  logic                       sum_ready_i,
    output logic [$clog2(ACC_LEN)-1:0] sample_cnt_o,
    output logic                       drop_o
`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_cnt_o
`endif
);

    localparam int CNT_WIDTH = $clog2(ACC_LEN);
    localparam logic [CNT_WIDTH-1:0] c_last_idx = CNT_WIDTH'(ACC_LEN - 1);

    // The output register is either empty (accumulating only) or full.
    typedef enum logic [0:0] {
        IDLE_ACC = 1'b0,
        HOLD     = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SUM_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic                   drop_q, drop_d;

    logic                   w_complete;
    logic                   w_handshake;
    logic [SUM_WIDTH-1:0]   w_frame_sum;

    // Running sum including the current sample; equals the frame sum on completion.
    always_comb begin
        w_frame_sum = acc_q + SUM_WIDTH'(pow_data_i);
        w_complete  = data_valid_i && (cnt_q == c_last_idx);
        w_handshake = (state_q == HOLD) && sum_ready_i;
    end

    // Accumulator and sample counter run regardless of the output state.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (data_valid_i) begin
            if (w_complete) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = w_frame_sum;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output-slot control: load, hold, release or discard a finished frame.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE_ACC: begin
                if (w_complete) begin
                    sum_d   = w_frame_sum;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (w_handshake && w_complete) begin
                    sum_d = w_frame_sum;
                end else if (w_handshake) begin
                    state_d = IDLE_ACC;
                end else if (w_complete) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE_ACC;
            end
        endcase
    end

    // State registers; reset discards any partial frame and held sum.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            drop_q  <= drop_d;
        end
    end

`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of discarded frames.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign sum_o        = sum_q;
    assign sum_valid_o  = (state_q == HOLD);
    assign sample_cnt_o = cnt_q;
    assign drop_o       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pow5_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_pow5_sum_accum
// Brief    : Self-checking bench for pow5_sum_accum: directed scenarios and a
//            randomized run, compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pow5_sum_accum;

    localparam int DATA_WIDTH = 8;
    localparam int IN_WIDTH   = 5 * DATA_WIDTH;
    localparam int ACC_LEN    = 4;
    localparam int SUM_WIDTH  = IN_WIDTH + $clog2(ACC_LEN);
    localparam int CNT_WIDTH  = $clog2(ACC_LEN);

    logic                 clk;
    logic                 rst_i;
    logic [IN_WIDTH-1:0]  pow_data_i;
    logic                 data_valid_i;
    logic [SUM_WIDTH-1:0] sum_o;
    logic                 sum_valid_o;
    logic                 sum_ready_i;
    logic [CNT_WIDTH-1:0] sample_cnt_o;
    logic                 drop_o;
`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
    logic [7:0]           drop_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the samples of the frame in progress plus the output slot.
    logic [63:0] m_frame[$];
    logic [63:0] m_sum;
    logic        m_valid;
    logic        m_drop;
    int          m_drop_cnt;

    pow5_sum_accum #(
        .DATA_WIDTH(DATA_WIDTH),
        .IN_WIDTH  (IN_WIDTH),
        .ACC_LEN   (ACC_LEN),
        .SUM_WIDTH (SUM_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pow_data_i  (pow_data_i),
        .data_valid_i(data_valid_i),
        .sum_o       (sum_o),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .sample_cnt_o(sample_cnt_o),
        .drop_o      (drop_o)
`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_sum      = '0;
        m_valid    = 1'b0;
        m_drop     = 1'b0;
        m_drop_cnt = 0;
    endtask

    task automatic compare_all();
        check("sum", 64'(sum_o), m_sum);
        check("sum_valid", 64'(sum_valid_o), 64'(m_valid));
        check("sample_cnt", 64'(sample_cnt_o), 64'(m_frame.size()));
        check("drop", 64'(drop_o), 64'(m_drop));
`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop_cnt));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cyc(input logic v, input logic [IN_WIDTH-1:0] d, input logic r);
        logic [63:0] s;
        logic        done;
        logic        hs;
        data_valid_i = v;
        pow_data_i   = d;
        sum_ready_i  = r;
        hs   = m_valid && r;
        done = 1'b0;
        s    = '0;
        if (v) begin
            m_frame.push_back(64'(d));
            if (m_frame.size() == ACC_LEN) begin
                done = 1'b1;
                foreach (m_frame[i]) s += m_frame[i];
                m_frame.delete();
            end
        end
        m_drop = 1'b0;
        if (!m_valid) begin
            if (done) begin
                m_sum   = s;
                m_valid = 1'b1;
            end
        end else if (hs) begin
            if (done) m_sum = s;
            else      m_valid = 1'b0;
        end else if (done) begin
            m_drop = 1'b1;
            if (m_drop_cnt < 255) m_drop_cnt++;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, r);
    endtask

    logic [IN_WIDTH-1:0] vals[4];

    initial begin
        vals[0] = 1; vals[1] = 32; vals[2] = 243; vals[3] = 1024;
        rst_i = 1'b0; data_valid_i = 1'b0; pow_data_i = '0; sum_ready_i = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst_i = 1'b1;

        // Frame 1..4 with the sink ready.
        for (int i = 0; i < 4; i++) cyc(1'b1, vals[i], 1'b1);
        check("f1_sum", 64'(sum_o), 64'd1300);
        check("f1_valid", 64'(sum_valid_o), 64'd1);
        idle(1, 1'b1);
        check("f1_released", 64'(sum_valid_o), 64'd0);

        // Gapped valid between samples 2 and 3.
        cyc(1'b1, vals[0], 1'b1);
        cyc(1'b1, vals[1], 1'b1);
        idle(3, 1'b1);
        cyc(1'b1, vals[2], 1'b1);
        cyc(1'b1, vals[3], 1'b1);
        check("gap_sum", 64'(sum_o), 64'd1300);
        idle(1, 1'b1);

        // Backpressure hold.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_sum", 64'(sum_o), 64'd128);
            idle(1, 1'b0);
        end
        idle(1, 1'b1);
        check("bp_release", 64'(sum_valid_o), 64'd0);

        // Drop: second frame completes while the first is still held.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 3125, 1'b0);
        check("drop_pulse", 64'(drop_o), 64'd1);
        check("drop_held", 64'(sum_o), 64'd4);
`ifdef POW5_SUM_ACCUM_DROP_CNT_EN
        check("drop_cnt1", 64'(drop_cnt_o), 64'd1);
`endif
        idle(1, 1'b0);
        check("drop_once", 64'(drop_o), 64'd0);

        // Handshake and completion in the same cycle.
        for (int i = 0; i < 3; i++) cyc(1'b1, 243, 1'b0);
        cyc(1'b1, 243, 1'b1);
        check("simul_valid", 64'(sum_valid_o), 64'd1);
        check("simul_sum", 64'(sum_o), 64'd972);
        check("simul_nodrop", 64'(drop_o), 64'd0);
        idle(1, 1'b1);

        // Asynchronous reset mid-frame.
        cyc(1'b1, 5, 1'b0);
        cyc(1'b1, 7, 1'b0);
        #3;
        rst_i = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_cnt", 64'(sample_cnt_o), 64'd0);
        #1;
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, vals[i], 1'b1);
        check("rst_sum", 64'(sum_o), 64'd1300);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rd;
            rd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rd = rd & 64'hFFF;
            cyc(($urandom_range(0, 9) < 6), rd[IN_WIDTH-1:0], ($urandom_range(0, 9) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pow5_sum_accum.md
Name: pow5_sum_accum

Overview:
- Downstream consumer of the pipelined fifth-power stage.
- Takes the 5*DATA_WIDTH-bit pow5 results and their valid strobe, and sums ACC_LEN consecutive valid results into one frame sum.
- Presents each frame sum on a valid/ready output port.
- The upstream stage has no backpressure, so this block keeps accumulating while a finished sum waits. A frame that completes while the output is still occupied is dropped and flagged.

Parameters:
- DATA_WIDTH, 8, operand width of the upstream pow5 stage.
- IN_WIDTH, 5*DATA_WIDTH, width of the incoming pow5 result.
- ACC_LEN, 4, valid samples per frame (>=2).
- SUM_WIDTH, IN_WIDTH+$clog2(ACC_LEN), frame sum width; overflow is impossible.

Ports:
- clk_i  in  1  clock, all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- pow_data_i  in  IN_WIDTH  pow5 result from the upstream stage.
- data_valid_i  in  1  pow_data_i is valid this cycle.
- sum_o  out  SUM_WIDTH  frame sum.
- sum_valid_o  out  1  sum_o holds an unconsumed frame sum.
- sum_ready_i  in  1  sink accepts sum_o; transfer happens when sum_valid_o && sum_ready_i.
- sample_cnt_o  out  $clog2(ACC_LEN)  samples accumulated in the current frame.
- drop_o  out  1  one-cycle pulse: a completed frame was discarded.

Behaviour:
- Reset (rst_i=0, async): sum_o=0, sum_valid_o=0, sample_cnt_o=0, drop_o=0, internal acc=0, state=IDLE_ACC.
- A reset mid-frame discards the partial accumulation and any held sum.
- Accumulation path (independent of state):
  - On each cycle with data_valid_i=1: acc += pow_data_i, zero-extended to SUM_WIDTH; sample_cnt_o increments.
  - Cycles with data_valid_i=0 change nothing.
  - Frame completes on a valid sample when sample_cnt_o==ACC_LEN-1. The completed value is acc+pow_data_i. On the next edge acc and sample_cnt_o both wrap to 0.
- State machine (two states):
  - IDLE_ACC, output empty: on frame completion, load sum_o with the completed value, set sum_valid_o=1 the next cycle, go to HOLD. Latency from the last valid sample to sum_valid_o is 1 cycle.
  - HOLD, output full: sum_o and sum_valid_o are held stable until the handshake.
    - Handshake without completion: sum_valid_o=0 next cycle, go to IDLE_ACC.
    - Handshake and completion in the same cycle: load the new sum, keep sum_valid_o=1, stay in HOLD. No drop.
    - Completion without handshake: the new frame is discarded, drop_o=1 for one cycle, held sum unchanged, acc cleared, stay in HOLD.
- sum_ready_i is ignored while sum_valid_o=0.
- drop_o is 0 in every cycle not described above.

Optional Feature:
- Macro: POW5_SUM_ACCUM_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt_o, 8 bits.
  - Reset to 0; increments on every drop_o pulse; saturates at 255.
- Not defined: port and counter are absent. drop_o behaviour is identical in both builds.

Test Plan:
- Reset then frame 1..4:
  - Drive pow_data_i = 1, 32, 243, 1024 with valid on 4 consecutive cycles; sum_ready_i=1.
  - Required: sum_valid_o=1 one cycle after the 4th sample, sum_o=1300, held for exactly 1 cycle.
- Gapped valid:
  - Same four values with data_valid_i=0 for 3 cycles between samples 2 and 3.
  - Required: sum_o=1300; sample_cnt_o sequence 0,1,2,2,2,2,3,0.
- Backpressure hold:
  - sum_ready_i=0; frame 32,32,32,32.
  - Required: sum_o=128, sum_valid_o=1, both stable for 10 cycles.
  - Then sum_ready_i=1 for 1 cycle -> sum_valid_o=0 the next cycle.
- Drop:
  - sum_ready_i=0; two frames: 1,1,1,1 then 3125×4.
  - Required: sum_o stays 4; drop_o pulses once on the 8th sample edge.
  - With the macro defined, drop_cnt_o=1.
- Simultaneous handshake and completion:
  - sum held at 4; sum_ready_i=1 in the same cycle as the 4th sample of frame 243×4.
  - Required: sum_valid_o stays 1, sum_o=972, drop_o=0.
- Async reset mid-frame:
  - After 2 samples, pulse rst_i=0 between clock edges.
  - Required: all outputs 0 immediately; the next frame 1, 32, 243, 1024 gives 1300.
